// File: rtl/cache_source.sv
// Direct-mapped byte-readable cache: NUM_LINES lines of 1024 bits, line fills, byte reads/stores, victim out.
// Latency 1 cycle, one op per cycle, no backpressure. Optional CACHE_STATS_EN adds saturating hit/miss counters.
module cache_source #(
    parameter int NUM_LINES = 8,
    parameter int LINE_BITS = 1024,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 control,
    input  logic [LINE_BITS-1:0] dataIn,
    input  logic [7:0]           progInput,
    input  logic                 progWe,
    output logic [7:0]           dataOut,
    output logic [LINE_BITS-1:0] memOut,
    output logic                 hit
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]          hitCount,
    output logic [15:0]          missCount
`endif
);

    localparam int OFF_W = 7;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_BITS - OFF_W - IDX_W;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;

    assign off = addr[OFF_W-1:0];
    assign idx = addr[OFF_W+IDX_W-1:OFF_W];
    assign tg  = addr[ADDR_BITS-1:OFF_W+IDX_W];

    logic [LINE_BITS-1:0] line_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;

    logic [7:0]           dataOut_q, dataOut_d;
    logic [LINE_BITS-1:0] memOut_q, memOut_d;
    logic                 hit_q, hit_d;

    logic line_wr, byte_wr, tag_wr;
    logic match;
    logic [7:0] fill_byte, line_byte;

    assign match     = valid_q[idx] && (tag_q[idx] == tg);
    assign fill_byte = dataIn[{off, 3'b000} +: 8];
    assign line_byte = line_q[idx][{off, 3'b000} +: 8];

    always_comb begin
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        dataOut_d = dataOut_q;
        memOut_d  = memOut_q;
        hit_d     = match;
        line_wr   = 1'b0;
        byte_wr   = 1'b0;
        tag_wr    = 1'b0;

        if (control) begin
            line_wr      = 1'b1;
            dataOut_d    = fill_byte;
            dirty_d[idx] = 1'b0;
            if (!match) begin
                // Only dirty victims carry data the memory controller must write back.
                memOut_d     = (valid_q[idx] && dirty_q[idx]) ? line_q[idx] : '0;
                tag_wr       = 1'b1;
                valid_d[idx] = 1'b1;
            end
        end else if (progWe) begin
            if (match) begin
                byte_wr      = 1'b1;
                dirty_d[idx] = 1'b1;
                dataOut_d    = progInput;
            end else begin
                dataOut_d = 8'h00;
            end
        end else begin
            dataOut_d = match ? line_byte : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            dirty_q   <= '0;
            dataOut_q <= 8'h00;
            memOut_q  <= '0;
            hit_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            dataOut_q <= dataOut_d;
            memOut_q  <= memOut_d;
            hit_q     <= hit_d;
        end
    end

    // Line data and tags are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (line_wr) line_q[idx] <= dataIn;
            if (byte_wr) line_q[idx][{off, 3'b000} +: 8] <= progInput;
            if (tag_wr)  tag_q[idx] <= tg;
        end
    end

    assign dataOut = dataOut_q;
    assign memOut  = memOut_q;
    assign hit     = hit_q;

`ifdef CACHE_STATS_EN
    logic [15:0] hitCount_q, hitCount_d;
    logic [15:0] missCount_q, missCount_d;

    always_comb begin
        hitCount_d  = hitCount_q;
        missCount_d = missCount_q;
        if (hit_d) begin
            if (hitCount_q != 16'hFFFF) hitCount_d = hitCount_q + 16'd1;
        end else begin
            if (missCount_q != 16'hFFFF) missCount_d = missCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hitCount_q  <= 16'h0000;
            missCount_q <= 16'h0000;
        end else begin
            hitCount_q  <= hitCount_d;
            missCount_q <= missCount_d;
        end
    end

    assign hitCount  = hitCount_q;
    assign missCount = missCount_q;
`endif

endmodule

// File: tb/tb_cache_source.sv
// Directed bench for cache_source: fills, byte reads/stores, evictions, write-back and reset priority.
module tb_cache_source;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   addr;
    logic          control;
    logic [1023:0] dataIn;
    logic [7:0]    progInput;
    logic          progWe;
    logic [7:0]    dataOut;
    logic [1023:0] memOut;
    logic          hit;
`ifdef CACHE_STATS_EN
    logic [15:0]   hitCount, missCount;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_source dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .control   (control),
        .dataIn    (dataIn),
        .progInput (progInput),
        .progWe    (progWe),
        .dataOut   (dataOut),
        .memOut    (memOut),
        .hit       (hit)
`ifdef CACHE_STATS_EN
        ,
        .hitCount  (hitCount),
        .missCount (missCount)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ctl, input logic we,
                        input logic [31:0] a, input logic [1023:0] din, input logic [7:0] pin);
        reset     = rst;
        control   = ctl;
        progWe    = we;
        addr      = a;
        dataIn    = din;
        progInput = pin;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic h, input logic [7:0] d,
                              input logic [63:0] mem_lo);
        chk({tag, ".hit"}, {63'b0, hit}, {63'b0, h});
        chk({tag, ".dataOut"}, {56'b0, dataOut}, {56'b0, d});
        chk({tag, ".memOut_lo"}, memOut[63:0], mem_lo);
        chk({tag, ".memOut_hi"}, {63'b0, |memOut[1023:64]}, 64'd0);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 32'h0, '0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 32'h0, '0, 8'h00);
        expect_out("reset", 1'b0, 8'h00, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0000, 1024'h01, 8'h00);
        expect_out("fill_0", 1'b0, 8'h01, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0008, 1024'h02, 8'h00);
        expect_out("fill_8_hit", 1'b1, 8'h00, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_03FF, 1024'h03, 8'h00);
        expect_out("fill_3ff", 1'b0, 8'h00, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0400, 1024'h04, 8'h00);
        expect_out("fill_400", 1'b0, 8'h04, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_1400, 1024'h05, 8'h00);
        expect_out("fill_1400", 1'b0, 8'h05, 64'h0);

        step(1'b0, 1'b0, 1'b1, 32'h0000_1405, '0, 8'hAB);
        expect_out("store_1405", 1'b1, 8'hAB, 64'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0000_1405, '0, 8'h00);
        expect_out("read_1405", 1'b1, 8'hAB, 64'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0000_0380, '0, 8'h00);
        expect_out("read_380", 1'b1, 8'h03, 64'h0);

        // Dirty victim: byte0=05 from fill, byte5=AB from store.
        step(1'b0, 1'b1, 1'b0, 32'h0000_0000, '0, 8'h00);
        expect_out("evict_dirty", 1'b0, 8'h00, 64'h0000_AB00_0000_0005);

        step(1'b0, 1'b0, 1'b1, 32'h0000_0003, '0, 8'h5A);
        expect_out("store_3", 1'b1, 8'h5A, 64'h0000_AB00_0000_0005);

        // Fill on a hit keeps memOut and cleans the line.
        step(1'b0, 1'b1, 1'b0, 32'h0000_0000, 1024'h22, 8'h00);
        expect_out("fill_hit_clean", 1'b1, 8'h22, 64'h0000_AB00_0000_0005);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0400, '0, 8'h00);
        expect_out("evict_clean", 1'b0, 8'h00, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0000, 1024'h33, 8'h00);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0001, '0, 8'h44);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0001, '0, 8'h00);
        expect_out("read_after_store", 1'b1, 8'h44, 64'h0);

        // Reset wins over a simultaneous fill.
        step(1'b1, 1'b1, 1'b0, 32'h0000_2000, 1024'h99, 8'h00);
        expect_out("reset_fill", 1'b0, 8'h00, 64'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0000_2000, '0, 8'h00);
        expect_out("read_after_reset_fill", 1'b0, 8'h00, 64'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0000_0000, '0, 8'h00);
        expect_out("read_0_after_reset", 1'b0, 8'h00, 64'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0000_0800, '0, 8'h00);
        expect_out("read_miss_800", 1'b0, 8'h00, 64'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0800, '0, 8'h77);
        expect_out("store_miss_800", 1'b0, 8'h00, 64'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0800, 1024'h11, 8'h00);
        expect_out("fill_800", 1'b0, 8'h11, 64'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0C00, '0, 8'h77);
        expect_out("store_miss_c00", 1'b0, 8'h00, 64'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0800, '0, 8'h00);
        expect_out("read_800_unmodified", 1'b1, 8'h11, 64'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0000_0C00, '0, 8'h00);
        expect_out("read_miss_c00", 1'b0, 8'h00, 64'h0);

        // Store-miss must not have dirtied line 0: a conflicting fill shows a clean victim.
        step(1'b0, 1'b1, 1'b0, 32'h0000_0C00, '0, 8'h00);
        expect_out("evict_after_store_miss", 1'b0, 8'h00, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_source.md
Name: cache_source

Overview:
- Direct-mapped, byte-readable cache: 8 lines of 1024 bits (128 bytes) each, with per-line valid/dirty/tag.
- Lines are filled from the memory side on `dataIn`; bytes are read or written by the program side.
- Evicted lines are presented on `memOut` so the memory controller can write back dirty data.
- Sits between the CPU load/store path and the line-wide main-memory interface.

Parameters:
- NUM_LINES, 8, number of cache lines; power of two; index width = log2(NUM_LINES).
- LINE_BITS, 1024, line width in bits; fixed at 1024, giving offset = addr[6:0].
- ADDR_BITS, 32, address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  32  byte address: offset [6:0], index [9:7], tag [31:10].
- control  input  1  1 = line fill from memory; 0 = program byte access.
- dataIn  input  1024  fill line; byte k = dataIn[8k+7:8k].
- progInput  input  8  byte write data for program stores.
- progWe  input  1  program store enable; only used when control=0; tie 0 if unused.
- dataOut  output  8  byte result, registered.
- memOut  output  1024  victim/write-back line, registered.
- hit  output  1  registered; 1 = the addressed line was valid with a matching tag before this operation.

Behaviour:
- All operations are sampled on the rising clk edge. Results appear on the outputs after that edge (1-cycle latency). Outputs hold until the next operation.
- Lookup: idx = addr[9:7], tg = addr[31:10], off = addr[6:0]. match = valid[idx] && tag[idx]==tg, evaluated on pre-edge state.
- Reset (reset=1 at edge): every valid and dirty bit is cleared; dataOut=0, memOut=0, hit=0. Line data and tags are not reset. Reset has priority over any operation presented in the same cycle.
- Fill (control=1), on a match:
  - line[idx] is overwritten with dataIn.
  - hit=1.
  - memOut is unchanged.
  - dirty[idx] is cleared.
- Fill (control=1), on a miss:
  - memOut <= old line[idx] if valid[idx] && dirty[idx], else 0.
  - Then line[idx] <= dataIn, tag[idx] <= tg, valid[idx] <= 1, dirty[idx] <= 0, hit=0.
- Fill, all cases: dataOut <= byte off of dataIn (the freshly filled byte).
- Read (control=0, progWe=0):
  - hit <= match.
  - dataOut <= byte off of line[idx] on a hit, else 0.
  - No state change; memOut unchanged.
- Store (control=0, progWe=1):
  - On a hit: byte off of line[idx] <= progInput, dirty[idx] <= 1, dataOut <= progInput, hit=1.
  - On a miss: no state change, dataOut <= 0, hit=0. The requester must fill the line, then retry.
- Offset range: every offset 0..127 is legal. Accesses never span lines; no alignment restriction.
- Conflicts: addresses differing only in tag (e.g. 0x0, 0x400, 0x1400, all idx 0) evict each other.
- Back-to-back operations are fully pipelined, one per cycle. A read the cycle after a store/fill to the same line sees the new data.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hitCount[15:0] and missCount[15:0].
  - Each non-reset operation increments exactly one of the two, according to the hit result.
  - Both counters saturate at 0xFFFF and clear on reset.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset, then fill addr=0x0, dataIn=0x01 -> hit=0, dataOut=0x01, memOut=0.
- Fill addr=0x8, dataIn=0x02 -> hit=1 (same line, tag 0), dataOut=0x00, memOut=0.
- Fill 0x3FF (dataIn=0x03), then 0x400 (dataIn=0x04), then 0x1400 (dataIn=0x05):
  - 0x3FF -> hit=0, dataOut=0x00.
  - 0x400 (idx 0, tag 1) -> hit=0, dataOut=0x04, memOut=0 (victim clean).
  - 0x1400 (idx 0, tag 5) -> hit=0, dataOut=0x05.
- Store addr=0x1405, progWe=1, progInput=0xAB -> hit=1, dataOut=0xAB. Then:
  - Read 0x1405 -> dataOut=0xAB.
  - Fill 0x0 with dataIn=0 -> hit=0, memOut has 0x05 in byte 0 and 0xAB in byte 5.
- Read/store on a miss (addr=0x800 after reset) -> hit=0, dataOut=0, no line modified.
- Assert reset in the same cycle as a fill -> fill ignored. A following read of that address -> hit=0, dataOut=0.
